tick_gen_multi: RTL and testbench
=================================

// Module: tick_gen_multi
// PURPOSE
//  Parametrised multi-channel tick generator: NUM_CH independent divide-by-D counters.
//  Each channel emits a one-clock strobe every D input clocks.
//  Provides the slow timing strobes for the ATM/vending FSMs: keypad scan, display refresh, timeouts.
//  Divisors are loaded at reset from a parameter and can be rewritten at runtime.
// PARAMETERS
//  NUM_CH       4           number of tick channels (1..16)
//  CNT_W        26          divisor/counter width; max divisor 2^CNT_W-1
//  DEFAULT_DIV  12_500_000  reset divisor for every channel (4 Hz strobe at 50 MHz)
// PORTS
//  clk_in       in   1            system clock, all logic on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  en           in   1            global run enable
//  sync_clr     in   1            synchronous clear of all counters/outputs
//  wr_en        in   1            divisor write strobe
//  wr_ch        in   $clog2(NUM_CH) (min 1)  channel addressed by write
//  wr_div       in   CNT_W        new divisor value
//  tick_out     out  NUM_CH       per-channel one-cycle strobe, registered
//  sq_out       out  NUM_CH       per-channel square wave (TICK_GEN_SQUARE_EN only)
// BEHAVIOUR
//  Reset (rst_n=0, async): div[i]=DEFAULT_DIV; cnt[i]=0; tick_out=0; sq_out=0.
//  Channel i with D=div[i]>=1 and en=1, each edge:
//  - cnt!=D-1: cnt<=cnt+1, tick<=0.
//  - cnt==D-1: cnt<=0, tick<=1.
//  => first tick after the D-th enabled edge, then exactly one high cycle every D edges.
//  D=1: tick_out held high continuously.
//  D=0: channel idle; cnt held 0, tick 0, sq held.
//  en=0: counters hold value; tick_out<=0 next edge; resume counts from held value.
//  sync_clr=1 (priority over en and wr_en for counters): all cnt<=0, tick<=0, sq<=0.
//   Divisors unchanged.
//  wr_en=1, wr_ch<NUM_CH: div[wr_ch]<=wr_div; that channel's cnt<=0, tick<=0 on the same edge.
//   Other channels unaffected. New period counts from the next edge.
//  Write coinciding with terminal count on the same channel: write wins, no tick that cycle.
//  wr_ch>=NUM_CH: write ignored.
//  sync_clr and wr_en together: divisor written, counters cleared.
//  Arithmetic: cnt is CNT_W bits, unsigned; wrap occurs only via terminal compare, never overflow.
//  rst_n asserted mid-period: everything returns to reset values immediately;
//   counting restarts from 0 after release.
// CONFIGURATION
//  TICK_GEN_SQUARE_EN defined:
//   - sq_out[i] toggles on every edge where tick_out[i] is set.
//   - Gives a 50% duty square wave with period 2*D.
//   - Cleared by reset/sync_clr/write.
//  TICK_GEN_SQUARE_EN undefined:
//   - sq_out tied to 0.
//   - No toggle flops synthesised.
// STRUCTURE
//  Package tick_gen_pkg:
//   - CNT_W default
//   - channel-index width function
//   - DEFAULT_DIV constant
//  Sub-module tick_gen_chan:
//   - one counter, divisor register, tick flop, optional sq flop
//   - inputs: en, clr, load, load_val
//  Top generates NUM_CH instances; decodes wr_ch into per-channel load strobes.
// TESTING (bench: NUM_CH=2, CNT_W=8, DEFAULT_DIV=5)
//  Release rst_n, en=1 -> tick_out[0] high on edges 5,10,15; exactly 1 cycle each.
//  Write ch1 D=3 at edge 7 -> ch1 ticks at edges 10,13,16; ch0 unchanged.
//  Write D=1 to ch0 -> tick_out[0] constant 1.
//  Write D=0 to ch0 -> tick_out[0] stays 0.
//  en low at count 2 for 4 cycles -> ticks suppressed; next tick 3 enabled edges after en returns.
//  sync_clr at count 4 -> no tick; next tick 5 edges later.
//  Write wr_ch=2 -> no state change.
//  With TICK_GEN_SQUARE_EN, D=5 -> sq_out[0] period 10 cycles, 5 high / 5 low.
//  Async rst_n pulse mid-period -> outputs 0 without waiting for a clock edge.
//  Divisors back to 5 after reset.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int CNT_W_DEF       = 26;
  localparam int DEFAULT_DIV_DEF = 12_500_000;

  // A single-channel build still needs a 1-bit address port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One divide-by-D tick channel: divisor register, counter, tick flop and,
// when TICK_GEN_SQUARE_EN is defined, a square-wave toggle flop.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             idle;
  logic             term;

  assign idle = (div_q == '0);
  assign term = (cnt_q == (div_q - CNT_W'(1)));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_RST;
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      if (load) begin
        div_q <= load_val;
      end
      // A write restarts the period, so it also beats a coinciding terminal count.
      if (clr || load) begin
        cnt_q <= '0;
        tick  <= 1'b0;
      end else if (idle) begin
        cnt_q <= '0;
        tick  <= 1'b0;
      end else if (!en) begin
        tick  <= 1'b0;
      end else if (term) begin
        cnt_q <= '0;
        tick  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        tick  <= 1'b0;
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sq <= 1'b0;
    end else if (clr || load) begin
      sq <= 1'b0;
    end else if (!idle && en && term) begin
      sq <= ~sq;
    end
  end
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent tick channels with a runtime-writable divisor per channel.
// Optional square-wave outputs are built only when TICK_GEN_SQUARE_EN is defined.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] sq_out
);

  logic [NUM_CH-1:0] load;

  // Out-of-range addresses match no channel, so such writes fall on the floor.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = wr_en && (wr_ch == CH_W'(i));

    tick_gen_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (sync_clr),
      .load     (load[i]),
      .load_val (wr_div),
      .tick     (tick_out[i]),
      .sq       (sq_out[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed and randomized checks of tick_gen_multi against an edge-counting model.
module tb_tick_gen_multi;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en, sync_clr, wr_en;
  logic       wr_ch;
  logic [7:0] wr_div;
  logic [1:0] tick_a, sq_a;

  logic       en_b, sync_clr_b, wr_en_b;
  logic [1:0] wr_ch_b;
  logic [7:0] wr_div_b;
  logic [2:0] tick_b, sq_b;

  int n_checks = 0;
  int n_errors = 0;

  // model: enabled edges since last clear/write, and divisor, per channel
  int         mn[2];
  int         mdiv[2];
  logic [1:0] mtick;

  always #5 clk_in = ~clk_in;

  tick_gen_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(5)) u_dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .tick_out (tick_a),
    .sq_out   (sq_a)
  );

  tick_gen_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(5)) u_dut_b (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en_b),
    .sync_clr (sync_clr_b),
    .wr_en    (wr_en_b),
    .wr_ch    (wr_ch_b),
    .wr_div   (wr_div_b),
    .tick_out (tick_b),
    .sq_out   (sq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_sq();
    logic [1:0] r;
    r = '0;
`ifdef TICK_GEN_SQUARE_EN
    for (int c = 0; c < 2; c++)
      r[c] = (mdiv[c] != 0) && (((mn[c] / mdiv[c]) % 2) == 1);
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mn[c]   = 0;
      mdiv[c] = 5;
    end
    mtick = '0;
  endtask

  // One clock edge: advance the model from the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk_in);
    for (int c = 0; c < 2; c++) begin
      bit ld;
      ld = wr_en && (int'(wr_ch) == c);
      if (ld) mdiv[c] = int'(wr_div);
      if (sync_clr || ld) begin
        mn[c]    = 0;
        mtick[c] = 1'b0;
      end else if (mdiv[c] == 0) begin
        mtick[c] = 1'b0;
      end else if (en) begin
        mn[c]++;
        mtick[c] = ((mn[c] % mdiv[c]) == 0);
      end else begin
        mtick[c] = 1'b0;
      end
    end
    #1;
    chk("model_tick", 32'(tick_a), 32'(mtick));
    chk("model_sq", 32'(sq_a), 32'(exp_sq()));
  endtask

  task automatic wr(input logic ch, input logic [7:0] d);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = 1'b0; wr_div = '0;
    en_b = 1'b0; sync_clr_b = 1'b0; wr_en_b = 1'b0; wr_ch_b = '0; wr_div_b = '0;
    model_reset();

    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_tick", 32'(tick_a), 32'd0);
    chk("reset_sq", 32'(sq_a), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // default divisor 5 on both; rewrite ch1 to 3 on edge 7
    for (int e = 1; e <= 16; e++) begin
      if (e == 7) begin
        wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd3;
      end
      step();
      wr_en = 1'b0;
      chk("p1_tick0", 32'(tick_a[0]), 32'((e % 5) == 0));
      chk("p1_tick1", 32'(tick_a[1]),
          32'((e < 7) ? ((e % 5) == 0) : ((e > 7) && (((e - 7) % 3) == 0))));
    end

    // D=1: continuous high
    wr(1'b0, 8'd1);
    chk("d1_write_edge", 32'(tick_a[0]), 32'd0);
    for (int e = 0; e < 5; e++) begin
      step();
      chk("d1_high", 32'(tick_a[0]), 32'd1);
    end

    // D=0: idle
    wr(1'b0, 8'd0);
    for (int e = 0; e < 6; e++) begin
      step();
      chk("d0_low", 32'(tick_a[0]), 32'd0);
    end

    // en low at count 2 for 4 cycles
    wr(1'b0, 8'd5);
    repeat (2) step();
    en = 1'b0;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("en_low_tick", 32'(tick_a[0]), 32'd0);
    end
    en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("en_resume", 32'(tick_a[0]), 32'(e == 3));
    end

    // sync_clr at count 4 suppresses the due tick
    wr(1'b0, 8'd5);
    repeat (4) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("clr_no_tick", 32'(tick_a[0]), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("clr_restart", 32'(tick_a[0]), 32'(e == 5));
    end

    // out-of-range write on the 3-channel instance is ignored;
    // that instance stays idle (en_b=0) so the tick vector must stay 0 and
    // its divisors still 5 later on
    wr_en_b = 1'b1; wr_ch_b = 2'd3; wr_div_b = 8'd2;
    step();
    wr_en_b = 1'b0;
    chk("oor_tick_b", 32'(tick_b), 32'd0);

    // square wave, D=5: 5 high / 5 low
    wr(1'b0, 8'd5);
    for (int e = 1; e <= 20; e++) begin
      step();
`ifdef TICK_GEN_SQUARE_EN
      chk("sq_wave", 32'(sq_a[0]), 32'(((e / 5) % 2) == 1));
`else
      chk("sq_tied", 32'(sq_a), 32'd0);
`endif
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      en       = ($urandom % 4) != 0;
      sync_clr = ($urandom % 25) == 0;
      wr_en    = ($urandom % 10) == 0;
      wr_ch    = 1'($urandom % 2);
      wr_div   = 8'($urandom % 8);
      step();
    end
    en = 1'b1; sync_clr = 1'b0; wr_en = 1'b0;

    // async reset mid-period while ch0 is held high
    wr(1'b0, 8'd1);
    repeat (2) step();
    chk("pre_rst_high", 32'(tick_a[0]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tick", 32'(tick_a), 32'd0);
    chk("async_rst_sq", 32'(sq_a), 32'd0);
    chk("async_rst_sq_b", 32'(sq_b), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    en_b  = 1'b1;

    // divisors back to 5; ignored wr_ch=3 write on the 3-channel instance
    for (int e = 1; e <= 10; e++) begin
      if (e == 2) begin
        wr_en_b = 1'b1; wr_ch_b = 2'd3; wr_div_b = 8'd2;
      end
      step();
      wr_en_b = 1'b0;
      chk("post_rst_tick", 32'(tick_a), 32'(((e % 5) == 0) ? 2'b11 : 2'b00));
      chk("oor_b_tick", 32'(tick_b), 32'(((e % 5) == 0) ? 3'b111 : 3'b000));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
